dm_arbiter: RTL and testbench

//  Shares the single data-memory port (DataMem: DMWr/MemOp/MemEXT/address/din/dout) between two requesters:
//  m0 = CPU load/store unit, m1 = debug/DMA loader. Per-request handshake, round-robin or fixed priority,

---
 rtl/dm_arbiter_pkg.sv | 25 ++
 rtl/dm_align_check.sv | 31 +++
 rtl/dm_arbiter.sv | 121 ++++++++++++
 tb/tb_dm_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, data window base,
// arbiter FSM states and the latched transaction record.
package dm_arbiter_pkg;

   localparam logic [1:0]  MEM_BYTE          = 2'b00;
   localparam logic [1:0]  MEM_HALF          = 2'b01;
   localparam logic [1:0]  MEM_WORD          = 2'b10;
   localparam logic [31:0] DATA_BASE_ADDRESS = 32'h1001_0000;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'b00,
      ARB_ACCESS = 2'b01,
      ARB_DONE   = 2'b10
   } arb_state_e;

   typedef struct packed {
      logic        we;
      logic [1:0]  memop;
      logic        memext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        id;
   } txn_t;

endpackage

// File: rtl/dm_align_check.sv
// Combinational legality check of one access: window range, natural alignment
// and the undefined size encoding.
module dm_align_check
   import dm_arbiter_pkg::*;
#(
   parameter int MEM_BYTES = 512
) (
   input  logic [1:0]  memop,
   input  logic [31:0] addr,
   output logic        err
);

   logic [31:0] off;
   logic        out_of_range;
   logic        misaligned;

   // Offset wraps, so addresses below the base land far above MEM_BYTES.
   always_comb begin
      off          = addr - DATA_BASE_ADDRESS;
      out_of_range = (off >= 32'(MEM_BYTES));
      misaligned   = 1'b0;
      case (memop)
         MEM_BYTE: misaligned = 1'b0;
         MEM_HALF: misaligned = off[0];
         MEM_WORD: misaligned = (off[1:0] != 2'b00);
         default:  misaligned = 1'b1;
      endcase
      err = out_of_range | misaligned;
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single DataMem port: picks a winner, checks the
// access, drives DataMem for one cycle and returns a registered ack/err/rdata.
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter bit RR_EN     = 1'b1,
   parameter int MEM_BYTES = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [1:0]  m0_memop,
   input  logic        m0_memext,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [1:0]  m1_memop,
   input  logic        m1_memext,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic        dm_we,
   output logic [1:0]  dm_memop,
   output logic        dm_memext,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata
);

   arb_state_e state, state_next;
   txn_t       cand, txn;
   logic       txn_err, cand_err;
   logic       rr_ptr;
   logic       any_req, grant_m1;

   // rr_ptr only breaks ties; a lone requester always wins.
   always_comb begin
      any_req  = m0_req | m1_req;
      grant_m1 = m1_req & (~m0_req | (RR_EN & rr_ptr));
      if (grant_m1)
         cand = '{we: m1_we, memop: m1_memop, memext: m1_memext,
                  addr: m1_addr, wdata: m1_wdata, id: 1'b1};
      else
         cand = '{we: m0_we, memop: m0_memop, memext: m0_memext,
                  addr: m0_addr, wdata: m0_wdata, id: 1'b0};
   end

   dm_align_check #(
      .MEM_BYTES (MEM_BYTES)
   ) u_check (
      .memop (cand.memop),
      .addr  (cand.addr),
      .err   (cand_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ARB_IDLE;
      else     state <= state_next;
   end

   // dm_we decodes straight from state so an async reset cuts a write at once.
   always_comb begin
      state_next = state;
      dm_we      = 1'b0;
      case (state)
         ARB_IDLE:   if (any_req) state_next = ARB_ACCESS;
         ARB_ACCESS: begin
            dm_we      = txn.we & ~txn_err;
            state_next = ARB_DONE;
         end
         ARB_DONE:   state_next = ARB_IDLE;
         default:    state_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txn     <= '0;
         txn_err <= 1'b0;
         rr_ptr  <= 1'b0;
      end else if (state == ARB_IDLE && any_req) begin
         txn     <= cand;
         txn_err <= cand_err;
         if (RR_EN) rr_ptr <= ~grant_m1;
      end
   end

   // Completion is reported one cycle after the access, during DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         m0_err   <= 1'b0;
         m1_err   <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else begin
         m0_ack <= (state == ARB_ACCESS) & ~txn.id;
         m1_ack <= (state == ARB_ACCESS) &  txn.id;
         m0_err <= (state == ARB_ACCESS) & ~txn.id & txn_err;
         m1_err <= (state == ARB_ACCESS) &  txn.id & txn_err;
         if (state == ARB_ACCESS && !txn.we && !txn_err) begin
            if (txn.id) m1_rdata <= dm_rdata;
            else        m0_rdata <= dm_rdata;
         end
      end
   end

   assign dm_memop  = txn.memop;
   assign dm_memext = txn.memext;
   assign dm_addr   = txn.addr;
   assign dm_wdata  = txn.wdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench: arbiter plus a small DataMem model; a second fixed-priority
// instance shares the requester inputs for the priority comparison.
module tb_dm_arbiter;
   import dm_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 0, m0_we = 0, m0_memext = 0;
   logic [1:0]  m0_memop = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0;
   logic        m1_req = 0, m1_we = 0, m1_memext = 0;
   logic [1:0]  m1_memop = 0;
   logic [31:0] m1_addr = 0, m1_wdata = 0;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        dm_we, dm_memext;
   logic [1:0]  dm_memop;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;

   logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
   logic [31:0] fp_m0_rdata, fp_m1_rdata;
   logic        fp_dm_we, fp_dm_memext;
   logic [1:0]  fp_dm_memop;
   logic [31:0] fp_dm_addr, fp_dm_wdata;

   logic [7:0]  mem [0:511];
   logic [31:0] wr_off, rd_off;
   logic [8:0]  rd_idx;
   int          we_count = 0;
   int          checks = 0, passes = 0;

   always #5 clk = ~clk;

   dm_arbiter #(.RR_EN(1'b1), .MEM_BYTES(512)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_memop(m0_memop), .m0_memext(m0_memext),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_memop(m1_memop), .m1_memext(m1_memext),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .dm_we(dm_we), .dm_memop(dm_memop), .dm_memext(dm_memext), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
   );

   dm_arbiter #(.RR_EN(1'b0), .MEM_BYTES(512)) dut_fp (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_memop(m0_memop), .m0_memext(m0_memext),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(fp_m0_ack), .m0_err(fp_m0_err), .m0_rdata(fp_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_memop(m1_memop), .m1_memext(m1_memext),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(fp_m1_ack), .m1_err(fp_m1_err), .m1_rdata(fp_m1_rdata),
      .dm_we(fp_dm_we), .dm_memop(fp_dm_memop), .dm_memext(fp_dm_memext), .dm_addr(fp_dm_addr),
      .dm_wdata(fp_dm_wdata), .dm_rdata(32'h0)
   );

   // DataMem model: little-endian bytes, writes on negedge, combinational read.
   always @(negedge clk) begin
      if (dm_we) begin
         we_count = we_count + 1;
         wr_off = dm_addr - DATA_BASE_ADDRESS;
         if (wr_off < 32'd512) begin
            mem[wr_off[8:0]] = dm_wdata[7:0];
            if (dm_memop == MEM_HALF || dm_memop == MEM_WORD)
               mem[wr_off[8:0] + 9'd1] = dm_wdata[15:8];
            if (dm_memop == MEM_WORD) begin
               mem[wr_off[8:0] + 9'd2] = dm_wdata[23:16];
               mem[wr_off[8:0] + 9'd3] = dm_wdata[31:24];
            end
         end
      end
   end

   always_comb begin
      rd_off   = dm_addr - DATA_BASE_ADDRESS;
      rd_idx   = rd_off[8:0];
      dm_rdata = 32'h0;
      if (rd_off < 32'd512) begin
         case (dm_memop)
            MEM_BYTE: dm_rdata = dm_memext ? {{24{mem[rd_idx][7]}}, mem[rd_idx]} : {24'h0, mem[rd_idx]};
            MEM_HALF: dm_rdata = dm_memext ? {{16{mem[rd_idx + 9'd1][7]}}, mem[rd_idx + 9'd1], mem[rd_idx]}
                                           : {16'h0, mem[rd_idx + 9'd1], mem[rd_idx]};
            default:  dm_rdata = {mem[rd_idx + 9'd3], mem[rd_idx + 9'd2], mem[rd_idx + 9'd1], mem[rd_idx]};
         endcase
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      checks++;
      if (got === expected) passes++;
      else $display("[TB] FAIL %s: got %h expected %h", tag, got, expected);
   endtask

   // One handshake from IDLE; returns rdata/err and cycles from request to ack.
   task automatic applyStimulus(input int master, input logic we, input logic [1:0] op,
                                input logic ext, input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err, output int lat);
      bit got = 0;
      rdata = 32'h0;
      err   = 1'b0;
      lat   = 0;
      if (master == 0) begin
         m0_we = we; m0_memop = op; m0_memext = ext; m0_addr = addr; m0_wdata = wdata; m0_req = 1;
      end else begin
         m1_we = we; m1_memop = op; m1_memext = ext; m1_addr = addr; m1_wdata = wdata; m1_req = 1;
      end
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk); #1;
         lat++;
         if (master == 0 ? m0_ack : m1_ack) begin
            got   = 1;
            rdata = (master == 0) ? m0_rdata : m1_rdata;
            err   = (master == 0) ? m0_err : m1_err;
         end
      end
      m0_req = 0;
      m1_req = 0;
      if (!got) checkOutput("ack timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat, we_before, cnt;
   int          rr_log [8];
   int          fp_log [8];
   int          rr_n, fp_n;

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset m0_ack", {31'd0, m0_ack}, 32'd0);
      checkOutput("reset m1_ack", {31'd0, m1_ack}, 32'd0);
      checkOutput("reset m0_err", {31'd0, m0_err}, 32'd0);
      checkOutput("reset m0_rdata", m0_rdata, 32'h0);
      checkOutput("reset m1_rdata", m1_rdata, 32'h0);
      checkOutput("reset dm_we", {31'd0, dm_we}, 32'd0);
      checkOutput("reset dm_addr", dm_addr, 32'h0);
      rst = 0;
      @(posedge clk); #1;

      applyStimulus(0, 1, MEM_WORD, 0, DATA_BASE_ADDRESS + 32'h10, 32'h12345678, rd, er, lat);
      checkOutput("m0 sw err", {31'd0, er}, 32'd0);
      checkOutput("m0 sw latency", lat, 32'd2);
      applyStimulus(0, 0, MEM_WORD, 0, DATA_BASE_ADDRESS + 32'h10, 32'h0, rd, er, lat);
      checkOutput("m0 lw rdata", rd, 32'h12345678);
      checkOutput("m0 lw err", {31'd0, er}, 32'd0);
      checkOutput("m0 lw latency", lat, 32'd2);

      applyStimulus(1, 1, MEM_BYTE, 0, DATA_BASE_ADDRESS + 32'h13, 32'h000000AB, rd, er, lat);
      checkOutput("m1 sb err", {31'd0, er}, 32'd0);
      checkOutput("m1 sb latency", lat, 32'd2);
      applyStimulus(1, 0, MEM_BYTE, 1, DATA_BASE_ADDRESS + 32'h13, 32'h0, rd, er, lat);
      checkOutput("m1 lb signed", rd, 32'hFFFFFFAB);
      applyStimulus(1, 0, MEM_BYTE, 0, DATA_BASE_ADDRESS + 32'h13, 32'h0, rd, er, lat);
      checkOutput("m1 lbu", rd, 32'h000000AB);
      applyStimulus(1, 0, MEM_WORD, 0, DATA_BASE_ADDRESS + 32'h10, 32'h0, rd, er, lat);
      checkOutput("m1 lw merged", rd, 32'hAB345678);
      checkOutput("m0 rdata held", m0_rdata, 32'h12345678);

      we_before = we_count;
      applyStimulus(0, 1, MEM_HALF, 0, DATA_BASE_ADDRESS + 32'h11, 32'h0000BEEF, rd, er, lat);
      checkOutput("misaligned sh err", {31'd0, er}, 32'd1);
      checkOutput("misaligned sh no write", we_count, we_before);
      applyStimulus(0, 0, MEM_WORD, 0, DATA_BASE_ADDRESS + 32'h10, 32'h0, rd, er, lat);
      checkOutput("word after bad sh", rd, 32'hAB345678);
      applyStimulus(0, 0, MEM_WORD, 0, DATA_BASE_ADDRESS + 32'h200, 32'h0, rd, er, lat);
      checkOutput("range err", {31'd0, er}, 32'd1);
      checkOutput("range rdata held", m0_rdata, 32'hAB345678);
      applyStimulus(0, 0, MEM_WORD, 0, DATA_BASE_ADDRESS - 32'h4, 32'h0, rd, er, lat);
      checkOutput("below base err", {31'd0, er}, 32'd1);
      applyStimulus(1, 0, 2'b11, 0, DATA_BASE_ADDRESS + 32'h10, 32'h0, rd, er, lat);
      checkOutput("memop 11 err", {31'd0, er}, 32'd1);
      applyStimulus(1, 0, MEM_WORD, 0, DATA_BASE_ADDRESS + 32'h1FC, 32'h0, rd, er, lat);
      checkOutput("last word ok", {31'd0, er}, 32'd0);

      we_before = we_count;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("idle no write", we_count, we_before);

      // Both requesters held with the pointer freshly reset to m0.
      rst = 1; #1; rst = 0;
      @(posedge clk); #1;
      m0_we = 0; m0_memop = MEM_WORD; m0_addr = DATA_BASE_ADDRESS + 32'h10;
      m1_we = 0; m1_memop = MEM_WORD; m1_addr = DATA_BASE_ADDRESS + 32'h10;
      m0_req = 1; m1_req = 1;
      rr_n = 0; fp_n = 0;
      for (int i = 0; i < 8; i++) begin rr_log[i] = -1; fp_log[i] = -1; end
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (m0_ack && rr_n < 8)    begin rr_log[rr_n] = 0; rr_n++; end
         if (m1_ack && rr_n < 8)    begin rr_log[rr_n] = 1; rr_n++; end
         if (fp_m0_ack && fp_n < 8) begin fp_log[fp_n] = 0; fp_n++; end
         if (fp_m1_ack && fp_n < 8) begin fp_log[fp_n] = 1; fp_n++; end
      end
      checkOutput("rr grant count", rr_n, 32'd4);
      checkOutput("rr grant 0", rr_log[0], 32'd0);
      checkOutput("rr grant 1", rr_log[1], 32'd1);
      checkOutput("rr grant 2", rr_log[2], 32'd0);
      checkOutput("rr grant 3", rr_log[3], 32'd1);
      checkOutput("fp grant count", fp_n, 32'd4);
      checkOutput("fp grant 0", fp_log[0], 32'd0);
      checkOutput("fp grant 1", fp_log[1], 32'd0);
      checkOutput("fp grant 2", fp_log[2], 32'd0);
      checkOutput("fp grant 3", fp_log[3], 32'd0);
      m0_req = 0;
      cnt = 0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         if (m1_ack) cnt = cnt + 1;
         if (fp_m1_ack) cnt = cnt + 10;
      end
      checkOutput("lone m1 granted", cnt, 32'd11);
      m1_req = 0;
      repeat (3) @(posedge clk);
      #1;

      // Reset lands mid-ACCESS of an m1 store.
      m1_we = 1; m1_memop = MEM_BYTE; m1_addr = DATA_BASE_ADDRESS + 32'h20; m1_wdata = 32'h55;
      m1_req = 1;
      @(posedge clk); #1;
      checkOutput("access dm_we", {31'd0, dm_we}, 32'd1);
      #1 rst = 1;
      #1;
      checkOutput("reset cuts dm_we", {31'd0, dm_we}, 32'd0);
      m1_req = 0;
      @(posedge clk); #1;
      rst = 0;
      cnt = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (m1_ack) cnt++;
      end
      checkOutput("no ack after reset", cnt, 32'd0);
      m0_we = 0; m0_memop = MEM_WORD; m0_addr = DATA_BASE_ADDRESS + 32'h10;
      m1_we = 0; m1_memop = MEM_WORD; m1_addr = DATA_BASE_ADDRESS + 32'h10;
      m0_req = 1; m1_req = 1;
      cnt = -1;
      for (int c = 0; c < 6 && cnt < 0; c++) begin
         @(posedge clk); #1;
         if (m0_ack) cnt = 0;
         else if (m1_ack) cnt = 1;
      end
      m0_req = 0; m1_req = 0;
      checkOutput("first grant after reset", cnt, 32'd0);
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
